// File: rtl/jescpu_core.sv
// jescpu_core: parametrised memory-to-memory CPU core.
//
// Every instruction reads its opcode and operand words from an external RAM.
// The operand words are addresses. Results go back to RAM or to an output
// channel. The core advances only on clk edges where step_en is high.
//
// Configuration macro: JESCPU_SHIFT_EN
//   When it is defined, opcodes 12 (SHL) and 13 (SHR) are legal.
//   When it is undefined, those opcodes halt the core like any other illegal
//   opcode.
//
// Opcodes: 0 NOP, 1 COPY, 2 ADD, 3 SUB, 4 XOR, 5 AND, 6 OR, 7 NOT, 8 JMP,
//          9 JZ, 10 OUT, 11 IN, [12 SHL, 13 SHR]
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   step_en      enables one state step on this clk edge
//   mem_addr     registered RAM address
//   mem_wdata    registered RAM write data
//   mem_we       registered RAM write enable
//   mem_rdata    RAM read data for the current mem_addr
//   in_data      input channel 0, sampled when IN executes
//   out_data     NUM_OUT channels of WIDTH bits; channel k at [k*WIDTH +: WIDTH]
//   out_strobe   one-clk pulse on channel k when that channel is written
//   halted       high in the HALT state
//   dbg_pc       program counter
//   dbg_opcode   latched opcode
//   dbg_state    current state encoding
module jescpu_core #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_en,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic                     mem_we,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic [WIDTH-1:0]         in_data,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_strobe,
  output logic                     halted,
  output logic [WIDTH-1:0]         dbg_pc,
  output logic [WIDTH-1:0]         dbg_opcode,
  output logic [3:0]               dbg_state
);

  localparam logic [3:0] S_PREFETCH = 4'd0;
  localparam logic [3:0] S_OPCODE   = 4'd1;
  localparam logic [3:0] S_OP1      = 4'd2;
  localparam logic [3:0] S_OP2      = 4'd3;
  localparam logic [3:0] S_IND1     = 4'd4;
  localparam logic [3:0] S_IND2     = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [WIDTH-1:0] OP_NOP  = WIDTH'(0);
  localparam logic [WIDTH-1:0] OP_COPY = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_ADD  = WIDTH'(2);
  localparam logic [WIDTH-1:0] OP_SUB  = WIDTH'(3);
  localparam logic [WIDTH-1:0] OP_XOR  = WIDTH'(4);
  localparam logic [WIDTH-1:0] OP_AND  = WIDTH'(5);
  localparam logic [WIDTH-1:0] OP_OR   = WIDTH'(6);
  localparam logic [WIDTH-1:0] OP_NOT  = WIDTH'(7);
  localparam logic [WIDTH-1:0] OP_JMP  = WIDTH'(8);
  localparam logic [WIDTH-1:0] OP_JZ   = WIDTH'(9);
  localparam logic [WIDTH-1:0] OP_OUT  = WIDTH'(10);
  localparam logic [WIDTH-1:0] OP_IN   = WIDTH'(11);
`ifdef JESCPU_SHIFT_EN
  localparam logic [WIDTH-1:0] OP_SHL  = WIDTH'(12);
  localparam logic [WIDTH-1:0] OP_SHR  = WIDTH'(13);
  localparam logic [WIDTH-1:0] OP_LAST = OP_SHR;
`else
  localparam logic [WIDTH-1:0] OP_LAST = OP_IN;
`endif

  logic [3:0]       state;
  logic [WIDTH-1:0] pc, opcode, operand1, operand2, value1, value2;
  logic [WIDTH-1:0] pc_plus1, pc_plus2, pc_plus3;
  logic [WIDTH-1:0] exec_wdata, exec_pc;
  logic             one_operand, writes_mem;

  assign pc_plus1 = pc + WIDTH'(1);
  assign pc_plus2 = pc + WIDTH'(2);
  assign pc_plus3 = pc + WIDTH'(3);

  // Single-operand read-modify-write instructions take the NOT path:
  // operand 1 is both the source address and the target address.
`ifdef JESCPU_SHIFT_EN
  assign one_operand = (opcode == OP_NOT) || (opcode == OP_SHL) || (opcode == OP_SHR);
`else
  assign one_operand = (opcode == OP_NOT);
`endif

  assign writes_mem = ((opcode >= OP_COPY) && (opcode <= OP_NOT)) ||
                      (opcode == OP_IN) || (one_operand && (opcode != OP_NOT));

  // Result word and next pc for the EXEC step.
  always_comb begin
    exec_wdata = value2;
    exec_pc    = pc_plus3;
    case (opcode)
      OP_ADD: exec_wdata = value1 + value2;
      OP_SUB: exec_wdata = value1 - value2;
      OP_XOR: exec_wdata = value1 ^ value2;
      OP_AND: exec_wdata = value1 & value2;
      OP_OR:  exec_wdata = value1 | value2;
      OP_NOT: begin
        exec_wdata = ~value1;
        exec_pc    = pc_plus2;
      end
`ifdef JESCPU_SHIFT_EN
      OP_SHL: begin
        exec_wdata = {value1[WIDTH-2:0], 1'b0};
        exec_pc    = pc_plus2;
      end
      OP_SHR: begin
        exec_wdata = {1'b0, value1[WIDTH-1:1]};
        exec_pc    = pc_plus2;
      end
`endif
      OP_IN:  exec_wdata = (operand2 == '0) ? in_data : '0;
      OP_JMP: exec_pc = operand1;
      OP_JZ:  exec_pc = (value1 == '0) ? operand2 : pc_plus3;
      default: exec_wdata = value2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PREFETCH;
      pc         <= '0;
      opcode     <= '0;
      operand1   <= '0;
      operand2   <= '0;
      value1     <= '0;
      value2     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      out_data   <= '0;
      out_strobe <= '0;
      halted     <= 1'b0;
    end else begin
      // The strobe is a single clk pulse whether or not the core is stepping.
      out_strobe <= '0;
      if (step_en) begin
        case (state)
          S_PREFETCH: begin
            mem_addr <= pc;
            mem_we   <= 1'b0;
            state    <= S_OPCODE;
          end
          S_OPCODE: begin
            opcode <= mem_rdata;
            if (mem_rdata == OP_NOP) begin
              pc    <= pc_plus1;
              state <= S_PREFETCH;
            end else if (mem_rdata > OP_LAST) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              mem_addr <= pc_plus1;
              state    <= S_OP1;
            end
          end
          S_OP1: begin
            operand1 <= mem_rdata;
            if (one_operand) begin
              mem_addr <= mem_rdata;
              state    <= S_IND1;
            end else if (opcode == OP_JMP) begin
              state <= S_EXEC;
            end else begin
              mem_addr <= pc_plus2;
              state    <= S_OP2;
            end
          end
          S_OP2: begin
            operand2 <= mem_rdata;
            if (opcode == OP_COPY) begin
              mem_addr <= mem_rdata;
              state    <= S_IND2;
            end else if (opcode == OP_IN) begin
              state <= S_EXEC;
            end else begin
              mem_addr <= operand1;
              state    <= S_IND1;
            end
          end
          S_IND1: begin
            value1 <= mem_rdata;
            if (one_operand || (opcode == OP_JZ) || (opcode == OP_OUT)) begin
              state <= S_EXEC;
            end else begin
              mem_addr <= operand2;
              state    <= S_IND2;
            end
          end
          S_IND2: begin
            value2 <= mem_rdata;
            state  <= S_EXEC;
          end
          S_EXEC: begin
            pc    <= exec_pc;
            state <= S_PREFETCH;
            // The write stays asserted until the next enabled PREFETCH.
            if (writes_mem) begin
              mem_addr  <= operand1;
              mem_wdata <= exec_wdata;
              mem_we    <= 1'b1;
            end
            // An out-of-range channel number matches no k and is ignored.
            if (opcode == OP_OUT) begin
              for (int k = 0; k < NUM_OUT; k++) begin
                if (operand2 == WIDTH'(k)) begin
                  out_data[k*WIDTH +: WIDTH] <= value1;
                  out_strobe[k]              <= 1'b1;
                end
              end
            end
          end
          S_HALT: state <= S_HALT;
          default: begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        endcase
      end
    end
  end

  assign dbg_pc     = pc;
  assign dbg_opcode = opcode;
  assign dbg_state  = state;

endmodule

// File: tb/tb_jescpu_core.sv
// tb_jescpu_core: random and directed stimulus for jescpu_core, checked
// against an instruction-level interpreter of the ISA.
// Instance u8 is the main 8-bit core. Instance u16 is a 16-bit core used
// for the shift opcodes.
module tb_jescpu_core;
  localparam int W  = 8;
  localparam int NO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- 8-bit core and its RAM ----------------
  logic              rst, step_en;
  logic [W-1:0]      mem_addr, mem_wdata, mem_rdata, in_data;
  logic              mem_we;
  logic [NO*W-1:0]   out_data;
  logic [NO-1:0]     out_strobe;
  logic              halted;
  logic [W-1:0]      dbg_pc, dbg_opcode;
  logic [3:0]        dbg_state;

  jescpu_core #(.WIDTH(W), .NUM_OUT(NO)) u8 (
    .clk(clk), .rst(rst), .step_en(step_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .in_data(in_data),
    .out_data(out_data), .out_strobe(out_strobe), .halted(halted),
    .dbg_pc(dbg_pc), .dbg_opcode(dbg_opcode), .dbg_state(dbg_state)
  );

  logic [W-1:0] ram [256];
  logic         tb_we8, tb_we16;
  logic [15:0]  tb_addr, tb_data;

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (tb_we8) ram[tb_addr[7:0]] <= tb_data[7:0];
    else if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // ---------------- 16-bit core and its RAM ----------------
  logic         rst16, step16, we16, halted16;
  logic [15:0]  addr16, wdata16, rdata16, in16, pc16, opc16;
  logic [31:0]  out16;
  logic [1:0]   strobe16;
  logic [3:0]   state16;

  jescpu_core #(.WIDTH(16), .NUM_OUT(2)) u16 (
    .clk(clk), .rst(rst16), .step_en(step16),
    .mem_addr(addr16), .mem_wdata(wdata16), .mem_we(we16),
    .mem_rdata(rdata16), .in_data(in16),
    .out_data(out16), .out_strobe(strobe16), .halted(halted16),
    .dbg_pc(pc16), .dbg_opcode(opc16), .dbg_state(state16)
  );

  logic [15:0] ram16 [65536];
  assign rdata16 = ram16[addr16];
  always @(posedge clk) begin
    if (tb_we16) ram16[tb_addr] <= tb_data;
    else if (we16) ram16[addr16] <= wdata16;
  end

  // ---------------- ISA-level reference model (8-bit core) ----------------
  logic [W-1:0] mdl_mem [256];
  logic [W-1:0] mdl_out [NO];
  logic [W-1:0] mdl_pc;
  logic         mdl_halt;

  // Interprets one whole instruction and reports its enabled-step count.
  task automatic model_step(output int steps, output logic [NO-1:0] stb,
                            output logic wr, output logic [W-1:0] wa);
    logic [W-1:0] op, a, b, va, vb, res;
    op = mdl_mem[mdl_pc];
    a  = mdl_mem[mdl_pc + 8'd1];
    b  = mdl_mem[mdl_pc + 8'd2];
    va = mdl_mem[a];
    vb = mdl_mem[b];
    stb = '0; wr = 1'b0; wa = a; res = '0; steps = 0;
    case (int'(op))
      0:  begin steps = 2; mdl_pc = mdl_pc + 8'd1; end
      1:  begin steps = 6; res = vb;      wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      2:  begin steps = 7; res = va + vb; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      3:  begin steps = 7; res = va - vb; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      4:  begin steps = 7; res = va ^ vb; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      5:  begin steps = 7; res = va & vb; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      6:  begin steps = 7; res = va | vb; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
      7:  begin steps = 5; res = ~va;     wr = 1'b1; mdl_pc = mdl_pc + 8'd2; end
      8:  begin steps = 4; mdl_pc = a; end
      9:  begin steps = 6; mdl_pc = (va == 8'd0) ? b : mdl_pc + 8'd3; end
      10: begin
        steps = 6;
        if (int'(b) < NO) begin
          mdl_out[b] = va;
          stb[b]     = 1'b1;
        end
        mdl_pc = mdl_pc + 8'd3;
      end
      11: begin steps = 5; res = (b == 8'd0) ? in_data : 8'd0; wr = 1'b1; mdl_pc = mdl_pc + 8'd3; end
`ifdef JESCPU_SHIFT_EN
      12: begin steps = 5; res = va << 1; wr = 1'b1; mdl_pc = mdl_pc + 8'd2; end
      13: begin steps = 5; res = va >> 1; wr = 1'b1; mdl_pc = mdl_pc + 8'd2; end
`endif
      default: begin steps = 2; mdl_halt = 1'b1; end
    endcase
    if (wr) mdl_mem[a] = res;
  endtask

  task automatic poke(input int a, input int d);
    tb_addr = 16'(a); tb_data = 16'(d); tb_we8 = 1'b1;
    @(posedge clk); #1;
    tb_we8 = 1'b0;
    mdl_mem[8'(a)] = 8'(d);
  endtask

  task automatic poke16(input int a, input int d);
    tb_addr = 16'(a); tb_data = 16'(d); tb_we16 = 1'b1;
    @(posedge clk); #1;
    tb_we16 = 1'b0;
  endtask

  // step_en is held high during reset so that rst has to win over it.
  task automatic do_reset();
    rst = 1'b1; step_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; step_en = 1'b0;
    mdl_pc = '0; mdl_halt = 1'b0;
    for (int k = 0; k < NO; k++) mdl_out[k] = '0;
  endtask

  // Runs one instruction on the DUT with step_en high on about 1 in duty
  // edges, then compares against the model.
  task automatic run_instr(input int duty, input string tag);
    int            steps, cnt, guard;
    logic [NO-1:0] stb;
    logic          wr;
    logic [W-1:0]  wa, op;
    logic [NO*W-1:0] out_exp;
    op = mdl_mem[mdl_pc];
    model_step(steps, stb, wr, wa);
    cnt = 0; guard = 0;
    while (cnt < steps && guard < 400) begin
      step_en = (duty <= 1) ? 1'b1 : ($urandom_range(duty - 1, 0) == 0);
      @(posedge clk); #1;
      if (step_en) cnt++;
      guard++;
    end
    step_en = 1'b0;
    check({tag, " step budget"}, 64'(cnt), 64'(steps));
    check({tag, " strobe"}, 64'(out_strobe), 64'(stb));
    @(posedge clk); #1;
    check({tag, " strobe clear"}, 64'(out_strobe), 64'(0));
    check({tag, " state"}, 64'(dbg_state), mdl_halt ? 64'd15 : 64'd0);
    check({tag, " pc"}, 64'(dbg_pc), 64'(mdl_pc));
    check({tag, " halted"}, 64'(halted), 64'(mdl_halt));
    for (int k = 0; k < NO; k++) out_exp[k*W +: W] = mdl_out[k];
    check({tag, " out_data"}, 64'(out_data), 64'(out_exp));
    if (wr) check({tag, " mem write"}, 64'(ram[wa]), 64'(mdl_mem[wa]));
    $display("instr %s: op=%0d steps=%0d pc->0x%0h", tag, op, steps, mdl_pc);
  endtask

  // Random program: instructions in 0x00..0x7F, data in 0x80..0xFF, jump
  // targets always at instruction starts, and a final JMP back to 0.
  task automatic gen_program();
    int p, op, len;
    int starts[$];
    int jumps[$];
    for (int i = 0; i < 256; i++)
      poke(i, (i < 128) ? 0 :
              ($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : int'($urandom_range(2, 0)));
    p = 0;
    while (p < 110) begin
      op  = int'($urandom_range(11, 0));
      len = (op == 0) ? 1 : (op == 7 || op == 8) ? 2 : 3;
      starts.push_back(p);
      poke(p, op);
      if (len > 1) poke(p + 1, int'($urandom_range(255, 128)));
      if (len > 2) poke(p + 2, (op == 10) ? int'($urandom_range(7, 0)) :
                               (op == 11) ? int'($urandom_range(1, 0)) :
                                            int'($urandom_range(255, 128)));
      if (op == 8) jumps.push_back(p + 1);
      if (op == 9) jumps.push_back(p + 2);
      p += len;
    end
    poke(p, 8);
    poke(p + 1, 0);
    foreach (jumps[j]) poke(jumps[j], starts[$urandom_range(starts.size() - 1, 0)]);
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; in_data = '0;
    tb_we8 = 1'b0; tb_we16 = 1'b0; tb_addr = '0; tb_data = '0;
    rst16 = 1'b1; step16 = 1'b0; in16 = '0;

    // Reset state
    do_reset();
    check("rst state", 64'(dbg_state), 64'd0);
    check("rst pc", 64'(dbg_pc), 64'd0);
    check("rst opcode", 64'(dbg_opcode), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_strobe", 64'(out_strobe), 64'd0);
    check("rst halted", 64'(halted), 64'd0);
    for (int i = 0; i < 256; i++) poke(i, 0);

    // ADD with wrap, step_en always high
    poke(0, 2); poke(1, 'h10); poke(2, 'h11); poke('h10, 200); poke('h11, 100);
    run_instr(1, "add");
    check("add wrap result", 64'(ram['h10]), 64'd44);
    check("add pc", 64'(dbg_pc), 64'd3);

    // Same ADD with step_en high about 1 in 4 edges
    do_reset();
    poke('h10, 200); poke('h11, 100);
    run_instr(4, "add slow");
    check("add slow result", 64'(ram['h10]), 64'd44);

    // OUT to channel 2, then to channel 7 (out of range)
    do_reset();
    poke(0, 10); poke(1, 'h20); poke(2, 2);
    poke(3, 10); poke(4, 'h20); poke(5, 7); poke('h20, 'hA5);
    run_instr(1, "out ch2");
    check("out ch2 data", 64'(out_data), 64'h00A5_0000);
    run_instr(1, "out ch7");
    check("out ch7 no change", 64'(out_data), 64'h00A5_0000);

    // JZ loop back to 0, then fall through
    do_reset();
    poke(0, 9); poke(1, 'h30); poke(2, 0); poke('h30, 0);
    run_instr(1, "jz taken");
    run_instr(2, "jz taken");
    check("jz loop pc", 64'(dbg_pc), 64'd0);
    poke('h30, 1);
    run_instr(1, "jz not taken");
    check("jz fall pc", 64'(dbg_pc), 64'd3);

    // Illegal opcode halts; only reset leaves HALT
    do_reset();
    poke(0, 'hFF);
    run_instr(1, "illegal");
    step_en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    step_en = 1'b0;
    check("halt held state", 64'(dbg_state), 64'd15);
    check("halt held flag", 64'(halted), 64'd1);
    check("halt held pc", 64'(dbg_pc), 64'd0);
    do_reset();
    check("halt exit state", 64'(dbg_state), 64'd0);
    check("halt exit pc", 64'(dbg_pc), 64'd0);
    check("halt exit flag", 64'(halted), 64'd0);

    // Reset during EXEC of COPY must cancel the write
    poke(0, 1); poke(1, 'h50); poke(2, 'h51); poke('h50, 'h11); poke('h51, 'h22);
    step_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("copy reached exec", 64'(dbg_state), 64'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst in exec mem_we", 64'(mem_we), 64'd0);
    check("rst in exec state", 64'(dbg_state), 64'd0);
    rst = 1'b0; step_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in exec target", 64'(ram['h50]), 64'h11);
    do_reset();

    // Random program with random step_en duty
    gen_program();
    for (int n = 0; n < 200; n++) begin
      in_data = 8'($urandom);
      run_instr(int'($urandom_range(3, 1)), "random");
    end
    for (int i = 0; i < 256; i++) check("final mem", 64'(ram[i]), 64'(mdl_mem[i]));

    // 16-bit core: shift opcodes, or HALT when they are not built in
    poke16(0, 12); poke16(1, 'h40); poke16('h40, 'h8001);
    poke16(2, 13); poke16(3, 'h41); poke16('h41, 'h8001);
    rst16 = 1'b1; step16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0; step16 = 1'b0;
`ifdef JESCPU_SHIFT_EN
    step16 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    step16 = 1'b0;
    @(posedge clk); #1;
    check("shl result", 64'(ram16['h40]), 64'h0002);
    check("shl pc", 64'(pc16), 64'd2);
    check("shl state", 64'(state16), 64'd0);
    step16 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    step16 = 1'b0;
    @(posedge clk); #1;
    check("shr result", 64'(ram16['h41]), 64'h4000);
    check("shr pc", 64'(pc16), 64'd4);
`else
    step16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step16 = 1'b0;
    @(posedge clk); #1;
    check("shl halts flag", 64'(halted16), 64'd1);
    check("shl halts state", 64'(state16), 64'd15);
    check("shl halts mem", 64'(ram16['h40]), 64'h8001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jescpu_core.md
Name: jescpu_core

Overview:
- Parametrised successor of the 8-bit memory-to-memory CPU: same 12-opcode ISA, generalised to WIDTH-bit words and NUM_OUT output channels.
- Adds a working IN, an explicit HALT state, and a step enable (replaces the derived slow clock).
- Memory sits outside the core on a sync-RAM port; top level wires it to ram, LedScan and the step divider.

Parameters:
- WIDTH, 8, data word and address width (memory depth 2^WIDTH); legal range 8..16.
- NUM_OUT, 4, number of OUT channels; legal range 1..8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- step_en  in  1  core advances only on clk edges where step_en=1
- mem_addr  out  WIDTH  registered RAM address
- mem_wdata  out  WIDTH  registered write data
- mem_we  out  1  registered write enable
- mem_rdata  in  WIDTH  RAM read data, valid 1 clk after mem_addr changes
- in_data  in  WIDTH  input channel 0, sampled in IN execute
- out_data  out  NUM_OUT*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_strobe  out  NUM_OUT  1-clk pulse on channel k when it is written
- halted  out  1  high in HALT
- dbg_pc  out  WIDTH  program counter
- dbg_opcode  out  WIDTH  latched opcode
- dbg_state  out  4  current state encoding

Behaviour:
- Reset: pc, opcode, operands, values, mem_addr, mem_wdata, mem_we, out_data, out_strobe, halted all 0; state PREFETCH. rst wins over step_en and aborts any instruction, including a pending write (mem_we forced 0).
- All state and register updates are qualified by step_en, except out_strobe, which always clears the next clk.
- States (encodings): PREFETCH=0, OPCODE=1, OP1=2, OP2=3, IND1=4, IND2=5, EXEC=6, HALT=15.
- PREFETCH: mem_addr<=pc, mem_we<=0.
- OPCODE: latch rdata.
  - NOP: pc+1 -> PREFETCH.
  - Opcode >=12 (12/13 with SHIFT_EN, see below): HALT.
  - Otherwise mem_addr<=pc+1 -> OP1.
- OP1: operand1<=rdata.
  - NOT: addr<=rdata -> IND1.
  - JMP: -> EXEC.
  - Else: addr<=pc+2 -> OP2.
- OP2: operand2<=rdata.
  - COPY: addr<=rdata -> IND2.
  - IN: -> EXEC.
  - Else: addr<=operand1 -> IND1.
- IND1: value1<=rdata.
  - NOT/JZ/OUT: -> EXEC.
  - Else: addr<=operand2 -> IND2.
- IND2: value2<=rdata -> EXEC.
- EXEC: always -> PREFETCH.
  - COPY/ADD/SUB/XOR/AND/OR: mem_addr<=operand1, mem_we<=1, wdata = value2 / v1+v2 / v1-v2 / ^ / & / | (mod 2^WIDTH, no flags); pc+3.
  - NOT: mem[operand1]<=~value1; pc+2.
  - JMP: pc<=operand1.
  - JZ: pc<=operand2 if value1==0, else pc+3.
  - OUT: if operand2<NUM_OUT, channel operand2<=value1 and its strobe pulses; else no effect (no halt). pc+3.
  - IN: mem[operand1]<=(operand2==0 ? in_data : 0); pc+3.
- HALT: terminal, halted=1; only rst exits.
- mem_we stays high until the next enabled PREFETCH. Repeated identical writes while step_en is low are legal.
- pc and pc+1/pc+2 wrap modulo 2^WIDTH.
- Step counts (enabled cycles, PREFETCH to next PREFETCH):
  - NOP 2, JMP 4, NOT/IN 5, COPY/JZ/OUT 6, binary ALU 7.

Optional Feature:
- Macro JESCPU_SHIFT_EN.
- When defined: opcodes 12 SHL and 13 SHR are legal. They follow the NOT path (one operand, 5 steps) and write mem[a]<=value1<<1 or >>1 (logical, zero fill); pc+2.
- When undefined: opcodes 12/13 go to HALT like any other illegal opcode.

Test Plan:
- WIDTH=8, mem[0..2]={2,0x10,0x11}, mem[0x10]=200, mem[0x11]=100, step_en=1 -> after 7 steps mem[0x10]=44 (wrap), pc=3.
- Program {10,0x20,2, 0,...}, mem[0x20]=0xA5, NUM_OUT=4 -> channel 2 = 0xA5, out_strobe=4'b0100 for exactly 1 clk. Repeat with operand2=7 -> no output change.
- JZ loop {9,0x30,0}, mem[0x30]=0 -> pc returns to 0 every 6 steps. With mem[0x30]=1 -> pc=3.
- Opcode 0xFF at pc=0 -> halted=1, dbg_state=15 after 2 steps; stays halted for 100 clks; rst -> pc=0, state 0.
- step_en toggled 1-in-4 on the ADD program -> same final memory as the step_en=1 run. Assert rst during EXEC of COPY -> target word unchanged.
- WIDTH=16, JESCPU_SHIFT_EN defined, {12,0x40}, mem[0x40]=0x8001 -> 0x0002. Undefined -> HALT.
